div_clk_monitor: RTL

Receiving-side checker for ripple-divided clocks: samples a divided clock (nominal ratio 2^SQUARE) in the fast `clk` domain, measures each period in `clk` cycles, and reports lock or error. It sits beside every `div_2_to_xth` instance whose output feeds logic, so a broken or mis-parameterised divider is caught at run time.

---
 rtl/clk_div_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/div_clk_monitor.sv | 133 +++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for ripple clock dividers and their monitors.
// Divide ratio and watchdog length are derived from the divider exponent.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        LOCKED
    } mon_state_t;

    function automatic int exp_period(input int square);
        return 1 << square;
    endfunction

    function automatic int timeout_period(input int square);
        return 4 * exp_period(square);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Both stages clear on reset so no stale edge survives it.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/div_clk_monitor.sv
// Measures each period of a divided clock in fast-clock cycles and
// reports lock once enough consecutive periods fall within tolerance.
module div_clk_monitor
    import clk_div_pkg::*;
#(
    parameter int SQUARE   = 1,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = SQUARE + 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div_in,
    input  logic             en,
    output logic [CNT_W-1:0] period_o,
    output logic             period_vld,
    output logic             locked,
    output logic             err_o
);

    localparam int EXP     = exp_period(SQUARE);
    localparam int TIMEOUT = timeout_period(SQUARE);
    localparam int LO      = (EXP > TOL) ? EXP - TOL : 0;
    localparam int HI      = (EXP + TOL > TIMEOUT) ? TIMEOUT : EXP + TOL;
    localparam int GW      = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] LO_V = CNT_W'(LO);
    localparam logic [CNT_W-1:0] HI_V = CNT_W'(HI);
    localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);
    localparam logic [GW-1:0]    LC_V = GW'(LOCK_CNT);

    logic s2, s3, re;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (clk_div_in),
        .q   (s2)
    );

    always_ff @(posedge clk) begin
        if (rst) s3 <= 1'b0;
        else     s3 <= s2;
    end

    assign re = s2 & ~s3;

    mon_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, meas, period_n;
    logic [GW-1:0]    gcnt, gcnt_n, gcnt_inc;
    logic             vld_n, err_n, good, at_timeout;

    assign meas       = cnt + CNT_W'(1);
    assign good       = (meas >= LO_V) && (meas <= HI_V);
    assign at_timeout = (meas == TO_V);
    assign gcnt_inc   = (gcnt == LC_V) ? gcnt : gcnt + GW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            gcnt       <= '0;
            period_o   <= '0;
            period_vld <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            gcnt       <= gcnt_n;
            period_o   <= period_n;
            period_vld <= vld_n;
            err_o      <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        gcnt_n   = gcnt;
        period_n = period_o;
        vld_n    = 1'b0;
        err_n    = err_o;
        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
            gcnt_n  = '0;
            err_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = ARM;
                    cnt_n   = '0;
                    gcnt_n  = '0;
                end
                ARM: begin
                    if (re) begin
                        state_n = MEASURE;
                        cnt_n   = '0;
                    end
                end
                MEASURE, LOCKED: begin
                    cnt_n = meas;
                    // A real edge takes priority over the watchdog
                    if (re) begin
                        cnt_n    = '0;
                        period_n = meas;
                        vld_n    = 1'b1;
                        if (good) begin
                            gcnt_n = gcnt_inc;
                            if (state == MEASURE && gcnt_inc == LC_V)
                                state_n = LOCKED;
                        end else begin
                            gcnt_n = '0;
                            if (state == LOCKED) begin
                                err_n   = 1'b1;
                                state_n = MEASURE;
                            end
                        end
                    end else if (at_timeout) begin
                        err_n   = 1'b1;
                        gcnt_n  = '0;
                        cnt_n   = '0;
                        state_n = ARM;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign locked = (state == LOCKED);

endmodule
